// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the microcontroller sequencer blocks.
//   ADDR_W       : program-memory address width
//   OP_JMP/OP_JMP_NZ : opcodes of the jump instructions in the IR high nibble
//   seq_state_t  : sequencer FSM state encoding
//   jump_target  : builds a jump address from the IR nibble
package cpu_pkg;

  localparam int ADDR_W = 8;

  localparam logic [3:0] OP_JMP    = 4'b1110;
  localparam logic [3:0] OP_JMP_NZ = 4'b1111;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } seq_state_t;

  // Jumps land on 16-instruction pages: the nibble is the high address bits.
  function automatic logic [ADDR_W-1:0] jump_target(input logic [3:0] nibble);
    return {nibble, {(ADDR_W-4){1'b0}}};
  endfunction

endpackage

// File: rtl/bp_compare.sv
// bp_compare -- address breakpoint comparator for the program sequencer.
// Built only when BREAKPOINT_EN is defined.
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   state               : current sequencer state
//   pm_addr             : fetch address of this cycle
//   bp_valid, bp_addr   : breakpoint arm and address
//   bp_match            : combinational match, requests HALT
//   bp_hit              : registered one-cycle pulse on breakpoint entry
module bp_compare
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  seq_state_t        state,
  input  logic [ADDR_W-1:0] pm_addr,
  input  logic              bp_valid,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_match,
  output logic              bp_hit
);

  // Set during the first RUN cycle after HALT so resuming never re-triggers.
  // STEP is excluded simply by matching only in RUN.
  logic mask_q;

  assign bp_match = bp_valid & (state == RUN) & ~mask_q & (pm_addr == bp_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= 1'b0;
      bp_hit <= 1'b0;
    end else begin
      mask_q <= (state == HALT);
      bp_hit <= bp_match;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer -- program counter / fetch-address generator with
// debug halt, single-step and optional address breakpoint.
// Optional feature macro: BREAKPOINT_EN (adds bp_valid, bp_addr, bp_hit).
// Ports:
//   clk, reset_n           : clock, async active-low reset
//   jmp, jmp_nz, dont_jmp  : jump controls from decoder / zero-flag qualifier
//   ir_nibble              : jump-target high nibble
//   halt_req, step         : debugger halt level and single-step pulse
//   bp_valid, bp_addr      : breakpoint arm and address (BREAKPOINT_EN)
//   pm_addr                : combinational fetch address
//   pc                     : address of the most recent fetch
//   ir_hold, halted        : IR load inhibit, sequencer halted
//   bp_hit                 : pulse on breakpoint entry (BREAKPOINT_EN)
//
// state | meaning
// BOOT  | first cycle after reset, fetches RESET_ADDR
// RUN   | free-running fetch, jumps honoured
// HALT  | frozen, pm_addr repeats pc, IR held
// STEP  | one fetch while halted, then back to HALT
module program_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jmp,
  input  logic              jmp_nz,
  input  logic              dont_jmp,
  input  logic [3:0]        ir_nibble,
  input  logic              halt_req,
  input  logic              step,
`ifdef BREAKPOINT_EN
  input  logic              bp_valid,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_hit,
`endif
  output logic [ADDR_W-1:0] pm_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              ir_hold,
  output logic              halted
);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_addr;
  logic              bp_match;

  assign target = {ir_nibble, {(ADDR_W-4){1'b0}}};

`ifdef BREAKPOINT_EN
  bp_compare #(.ADDR_W(ADDR_W)) u_bp_compare (
    .clk      (clk),
    .reset_n  (reset_n),
    .state    (state),
    .pm_addr  (pm_addr),
    .bp_valid (bp_valid),
    .bp_addr  (bp_addr),
    .bp_match (bp_match),
    .bp_hit   (bp_hit)
  );
`else
  assign bp_match = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
      pc    <= RESET_ADDR;
    end else begin
      state <= state_nxt;
      pc    <= pm_addr;
    end
  end

  // Fetch address kept in its own process: bp_match depends on pm_addr and
  // feeds the next-state logic, so merging them would form a false loop.
  always_comb begin
    next_addr = pc + ADDR_W'(1);
    if (jmp) begin
      next_addr = target;
    end else if (jmp_nz && !dont_jmp) begin
      next_addr = target;
    end

    pm_addr = next_addr;
    case (state)
      BOOT:    pm_addr = RESET_ADDR;
      HALT:    pm_addr = pc;
      default: pm_addr = next_addr;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT: state_nxt = halt_req ? HALT : RUN;
      RUN: begin
        if (halt_req || bp_match) state_nxt = HALT;
      end
      HALT: begin
        if (!halt_req)  state_nxt = RUN;
        else if (step)  state_nxt = STEP;
      end
      STEP:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  assign halted  = (state == HALT);
  assign ir_hold = (state == HALT);

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       jmp, jmp_nz, dont_jmp, halt_req, step;
  logic [3:0] ir_nibble;
  logic [7:0] pm_addr, pc;
  logic       ir_hold, halted;
`ifdef BREAKPOINT_EN
  logic       bp_valid;
  logic [7:0] bp_addr;
  logic       bp_hit;
`endif

  always #5 clk = ~clk;

  program_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .jmp       (jmp),
    .jmp_nz    (jmp_nz),
    .dont_jmp  (dont_jmp),
    .ir_nibble (ir_nibble),
    .halt_req  (halt_req),
    .step      (step),
`ifdef BREAKPOINT_EN
    .bp_valid  (bp_valid),
    .bp_addr   (bp_addr),
    .bp_hit    (bp_hit),
`endif
    .pm_addr   (pm_addr),
    .pc        (pc),
    .ir_hold   (ir_hold),
    .halted    (halted)
  );

  typedef struct {
    logic       jmp;
    logic       jmp_nz;
    logic       dont_jmp;
    logic [3:0] nib;
    logic       halt_req;
    logic       step;
    logic [7:0] exp_pm;
    logic [7:0] exp_pc;
    logic       exp_halted;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] last_pm;
  int         n_vec = 0;
  int         n_err = 0;

  // pc in a row is always the pm_addr expected in the previous row.
  task automatic add(input logic j, input logic jn, input logic dj, input logic [3:0] nib,
                     input logic hr, input logic st, input logic [7:0] pm, input logic hl);
    vec_t v;
    v.jmp = j; v.jmp_nz = jn; v.dont_jmp = dj; v.nib = nib;
    v.halt_req = hr; v.step = st;
    v.exp_pm = pm; v.exp_pc = last_pm; v.exp_halted = hl;
    last_pm = pm;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic [7:0] pm, input logic [7:0] pcv,
                             input logic hl);
    check({tag, " pm_addr"}, pm_addr, pm);
    check({tag, " pc"}, pc, pcv);
    check({tag, " halted"}, {7'b0, halted}, {7'b0, hl});
    check({tag, " ir_hold"}, {7'b0, ir_hold}, {7'b0, hl});
  endtask

  task automatic set_in(input logic j, input logic jn, input logic dj, input logic [3:0] nib,
                        input logic hr, input logic st);
    jmp = j; jmp_nz = jn; dont_jmp = dj; ir_nibble = nib; halt_req = hr; step = st;
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(0, 0, 0, 4'h0, 0, 0);
`ifdef BREAKPOINT_EN
    bp_valid = 1'b0;
    bp_addr  = 8'h00;
`endif

    // ---------------- vector table ----------------
    last_pm = 8'h00;
    add(0, 0, 0, 4'h0, 0, 0, 8'h00, 0);   // BOOT
    add(0, 0, 0, 4'h0, 0, 0, 8'h01, 0);
    add(0, 0, 0, 4'h0, 0, 0, 8'h02, 0);
    add(0, 1, 1, 4'h7, 0, 0, 8'h03, 0);   // jmp_nz suppressed
    add(1, 0, 0, 4'h1, 0, 0, 8'h10, 0);
    add(0, 0, 0, 4'h0, 0, 0, 8'h11, 0);
    add(0, 0, 0, 4'h0, 0, 0, 8'h12, 0);
    add(0, 0, 0, 4'h0, 0, 0, 8'h13, 0);
    add(1, 0, 0, 4'hA, 0, 0, 8'hA0, 0);   // pc=13, jmp to A0 same cycle
    add(1, 0, 0, 4'h4, 0, 0, 8'h40, 0);
    add(0, 1, 1, 4'h3, 0, 0, 8'h41, 0);   // pc=40, dont_jmp=1
    add(1, 0, 0, 4'h4, 0, 0, 8'h40, 0);
    add(0, 1, 0, 4'h3, 0, 0, 8'h30, 0);   // pc=40, dont_jmp=0
    add(1, 0, 0, 4'hF, 0, 0, 8'hF0, 0);
    for (int k = 1; k < 16; k++) add(0, 0, 0, 4'h0, 0, 0, 8'hF0 + 8'(k), 0);
    add(0, 0, 0, 4'h0, 0, 0, 8'h00, 0);   // FF wraps to 00
    for (int k = 1; k < 6; k++) add(0, 0, 0, 4'h0, 0, 0, 8'(k), 0);
    add(0, 0, 0, 4'h0, 1, 0, 8'h06, 0);   // halt_req sampled at pc=05
    add(0, 0, 0, 4'h0, 1, 0, 8'h06, 1);   // HALT
    add(1, 0, 0, 4'h9, 1, 0, 8'h06, 1);   // jmp ignored in HALT
    add(0, 0, 0, 4'h0, 1, 1, 8'h06, 1);   // step sampled
    add(0, 0, 0, 4'h0, 1, 0, 8'h07, 0);   // STEP
    add(0, 0, 0, 4'h0, 1, 0, 8'h07, 1);   // back in HALT
    add(0, 0, 0, 4'h0, 0, 0, 8'h07, 1);   // drop halt_req
    add(0, 0, 0, 4'h0, 0, 0, 8'h08, 0);   // RUN again
    add(0, 0, 0, 4'h0, 0, 1, 8'h09, 0);   // step ignored in RUN
    add(0, 0, 0, 4'h0, 0, 0, 8'h0A, 0);

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check_cycle("reset", 8'h00, 8'h00, 0);
`ifdef BREAKPOINT_EN
    check("reset bp_hit", {7'b0, bp_hit}, 8'h00);
`endif
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      set_in(vecs[i].jmp, vecs[i].jmp_nz, vecs[i].dont_jmp, vecs[i].nib,
             vecs[i].halt_req, vecs[i].step);
      @(negedge clk);
      check_cycle($sformatf("vec%0d", i), vecs[i].exp_pm, vecs[i].exp_pc, vecs[i].exp_halted);
      @(posedge clk);
      #1;
    end

    // ---------------- reset mid-operation with jmp active ----------------
    set_in(1, 0, 0, 4'h5, 0, 0);
    @(negedge clk);
    check("midrst pre pm_addr", pm_addr, 8'h50);
    #2;
    reset_n = 1'b0;
    #1;
    check_cycle("midrst async", 8'h00, 8'h00, 0);
`ifdef BREAKPOINT_EN
    check("midrst bp_hit", {7'b0, bp_hit}, 8'h00);
`endif
    @(posedge clk);
    #1;
    set_in(0, 0, 0, 4'h0, 0, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_cycle("midrst boot", 8'h00, 8'h00, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_cycle("midrst run", 8'h01, 8'h00, 0);

    // ---------------- BOOT straight into HALT ----------------
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    halt_req = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_cycle("boothalt boot", 8'h00, 8'h00, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_cycle("boothalt halt", 8'h00, 8'h00, 1);
    halt_req = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_cycle("boothalt run", 8'h01, 8'h00, 0);
    @(posedge clk);
    #1;

`ifdef BREAKPOINT_EN
    // ---------------- breakpoint at 20 ----------------
    bp_valid = 1'b1;
    bp_addr  = 8'h20;
    set_in(1, 0, 0, 4'h1, 0, 0);
    @(negedge clk);
    check_cycle("bp jump", 8'h10, 8'h01, 0);
    @(posedge clk);
    #1;
    jmp = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check_cycle($sformatf("bp walk%0d", k), 8'h10 + 8'(k), 8'h0F + 8'(k), 0);
      check($sformatf("bp walk%0d bp_hit", k), {7'b0, bp_hit}, 8'h00);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_cycle("bp halted", 8'h20, 8'h20, 1);
    check("bp halted bp_hit", {7'b0, bp_hit}, 8'h01);
    @(posedge clk);
    #1;
    set_in(1, 0, 0, 4'h2, 0, 0);          // refetch 20 in the masked cycle
    @(negedge clk);
    check_cycle("bp resume", 8'h20, 8'h20, 0);
    check("bp resume bp_hit", {7'b0, bp_hit}, 8'h00);
    @(posedge clk);
    #1;
    jmp = 1'b0;
    @(negedge clk);
    check_cycle("bp after1", 8'h21, 8'h20, 0);
    check("bp after1 bp_hit", {7'b0, bp_hit}, 8'h00);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_cycle("bp after2", 8'h22, 8'h21, 0);
    check("bp after2 bp_hit", {7'b0, bp_hit}, 8'h00);
    @(posedge clk);
    #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
